qnigma_tx_arb: RTL and testbench
================================

Name: qnigma_tx_arb

Overview:
- Round-robin frame arbiter that shares one byte-wide transmit path (the CDC FIFO write side) between NUM_REQ frame sources in the same clock domain.
- Grants whole frames, never individual bytes.
- Enforces a minimum idle gap between frames, a start-of-frame timeout, and a maximum frame length.
- Sits between the protocol engines (e.g. ARP, ICMP, TCP TX) and the MAC TX CDC write port.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- IFG_CYCLES, 12, minimum idle cycles on valid_out between frames (>=1).
- START_TIMEOUT, 16, cycles a granted requester has to assert its first valid.
- MAX_LEN, 1518, maximum bytes forwarded per frame.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- req  in  NUM_REQ  requester i has a frame ready; held until its frame ends
- gnt  out  NUM_REQ  one-hot grant, all-zero when idle
- data_in  in  NUM_REQ*8  packed byte per requester (requester i at [8i+7:8i])
- valid_in  in  NUM_REQ  byte valid per requester
- error_in  in  NUM_REQ  requester flags its current frame bad
- data_out  out  8  byte to CDC
- valid_out  out  1  byte valid to CDC
- error_out  out  1  frame error marker to CDC
- busy  out  1  high in any state other than IDLE

Behaviour:
- One clock, clk. Reset is synchronous and active-high on rst.
- Reset values:
  - gnt=0, data_out=0, valid_out=0, error_out=0, busy=0.
  - State IDLE; round-robin pointer = 0; all counters = 0.
- Outputs data_out, valid_out and error_out are registered: 1-cycle latency from the granted requester's inputs.
- States and transitions:
  - IDLE: if any req is high, select the first requester at or after the pointer, wrapping modulo NUM_REQ. Next cycle: gnt one-hot for it, state GRANT, timeout counter cleared. Requester i may act on gnt in the cycle gnt is first high.
  - GRANT: wait for valid_in[g].
    - On valid_in[g]: forward the byte, length=1, go to XFER.
    - If START_TIMEOUT cycles pass without valid: drop gnt, pulse error_out for 1 cycle with valid_out=0, go to GAP.
  - XFER: each cycle with valid_in[g]=1 forwards a byte and increments length.
    - First cycle with valid_in[g]=0 ends the frame: gnt cleared next cycle, go to GAP. Any req/valid in that cycle is ignored.
    - A byte arriving when length==MAX_LEN is not forwarded: error_out=1, valid_out=0 for one cycle, go to DRAIN.
    - error_in[g] high on any forwarded byte sets a sticky flag. error_out is driven 1 in the cycle after the last forwarded byte, with valid_out=0.
  - DRAIN: gnt stays asserted. Discard bytes until valid_in[g]=0, then go to GAP.
  - GAP: gnt=0. Count IFG_CYCLES, then go to IDLE.
    - Pointer = (g+1) mod NUM_REQ, updated on entry to GAP.
    - The earliest next gnt is IFG_CYCLES+1 cycles after GAP entry.
- Fairness: with all req high, grants rotate 0,1,2,3,0...
- A requester whose req drops before being granted is skipped.
- req of the granted requester is not sampled after grant. The frame end is defined only by valid.
- Inputs from non-granted requesters are ignored entirely.
- The length counter is 16 bits and saturates; MAX_LEN must be <=65535.
- rst mid-frame:
  - Outputs go to reset values in the next cycle. The truncated frame is not flagged.
  - The CDC/MAC treats the missing continuation as a runt.
- error_out and valid_out are never both high.

Decomposition:
- Package qnigma_pkg holds:
  - constants TX_ARB_NUM_REQ, TX_ARB_IFG, TX_ARB_START_TIMEOUT, TX_ARB_MAX_LEN;
  - the state enum typedef tx_arb_state_t (IDLE, GRANT, XFER, DRAIN, GAP).
- One sub-module, qnigma_rr_pick: combinational round-robin selector (req, pointer -> one-hot pick, any). It is reusable elsewhere.
- The arbiter module holds the FSM, counters and output registers.

Test Plan:
- Single frame: req[2]=1, then 5 bytes 0x11..0x55 on valid_in[2] -> gnt=4'b0100; valid_out high 5 consecutive cycles, each byte one cycle after its input; error_out=0; next grant no earlier than 13 cycles after valid_out falls.
- Fairness: all req=4'hF, each requester sends 3-byte frames -> grant order 0,1,2,3,0; no frame interleaving; each inter-frame idle on valid_out >=12 cycles.
- Oversize: MAX_LEN=8, requester sends 10 bytes -> exactly 8 bytes forwarded; then a 1-cycle error_out with valid_out=0; remaining 2 bytes dropped; gnt held until valid_in falls.
- Start timeout: req[1]=1 with valid never asserted -> gnt[1] high for 16 cycles, then error_out pulse, GAP, and pointer advances to 2.
- Error flag: error_in[0] high on byte 3 of 6 -> all 6 bytes forwarded, then error_out=1 for one cycle after the last byte.
- Reset mid-XFER: rst asserted on byte 4 -> next cycle valid_out=0, gnt=0, busy=0; after release, req[3] is granted first when pointer=0 and only req[3] is high.

Source files
------------

// File: rtl/qnigma_pkg.sv
// Shared constants and types for the qnigma transmit path.
package qnigma_pkg;

  localparam int TX_ARB_NUM_REQ       = 4;
  localparam int TX_ARB_IFG           = 12;
  localparam int TX_ARB_START_TIMEOUT = 16;
  localparam int TX_ARB_MAX_LEN       = 1518;

  typedef enum logic [2:0] {
    IDLE,
    GRANT,
    XFER,
    DRAIN,
    GAP
  } tx_arb_state_t;

endpackage

// File: rtl/qnigma_rr_pick.sv
// Combinational round-robin selector: first set req bit at or after ptr,
// wrapping modulo N, returned one-hot.
module qnigma_rr_pick #(
  parameter  int N  = 4,
  localparam int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  pick,
  output logic          any
);

  logic          found;
  logic [IW-1:0] idx;

  always_comb begin
    pick  = '0;
    found = 1'b0;
    idx   = '0;
    for (int k = 0; k < N; k++) begin
      idx = IW'((int'(ptr) + k) % N);
      if (!found && req[idx]) begin
        pick[idx] = 1'b1;
        found     = 1'b1;
      end
    end
  end

  assign any = |req;

endmodule

// File: rtl/qnigma_tx_arb.sv
// Round-robin frame arbiter feeding the MAC TX CDC write port: grants whole
// frames, enforces start timeout, maximum length and inter-frame gap.
module qnigma_tx_arb
  import qnigma_pkg::*;
#(
  parameter int NUM_REQ       = TX_ARB_NUM_REQ,
  parameter int IFG_CYCLES    = TX_ARB_IFG,
  parameter int START_TIMEOUT = TX_ARB_START_TIMEOUT,
  parameter int MAX_LEN       = TX_ARB_MAX_LEN
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_REQ-1:0]   req,
  output logic [NUM_REQ-1:0]   gnt,
  input  logic [NUM_REQ*8-1:0] data_in,
  input  logic [NUM_REQ-1:0]   valid_in,
  input  logic [NUM_REQ-1:0]   error_in,
  output logic [7:0]           data_out,
  output logic                 valid_out,
  output logic                 error_out,
  output logic                 busy
);

  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  tx_arb_state_t      state, state_d;
  logic [NUM_REQ-1:0] gnt_d;
  logic [IW-1:0]      g, g_d, ptr, ptr_d, ptr_next;
  logic [15:0]        cnt, cnt_d, len, len_d;
  logic               flag, flag_d;
  logic [7:0]         data_d;
  logic               valid_d, error_d;

  logic [NUM_REQ-1:0] pick;
  logic               any;
  logic [IW-1:0]      pick_idx;
  logic [7:0]         byte_g;
  logic               valid_g, error_g;

  qnigma_rr_pick #(.N(NUM_REQ)) u_pick (
    .req  (req),
    .ptr  (ptr),
    .pick (pick),
    .any  (any)
  );

  always_comb begin
    pick_idx = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (pick[i]) pick_idx = IW'(i);
    end
  end

  // Only the granted requester's lanes are ever looked at.
  assign byte_g   = data_in[8*int'(g) +: 8];
  assign valid_g  = valid_in[g];
  assign error_g  = error_in[g];
  assign ptr_next = (g == IW'(NUM_REQ - 1)) ? '0 : g + 1'b1;
  assign busy     = (state != IDLE);

  // NOTE: every variable gets a default before the case so no path leaves it
  // unassigned; without that this block would infer latches.
  always_comb begin
    state_d = state;
    gnt_d   = gnt;
    g_d     = g;
    ptr_d   = ptr;
    cnt_d   = cnt;
    len_d   = len;
    flag_d  = flag;
    data_d  = data_out;
    valid_d = 1'b0;
    error_d = 1'b0;
    case (state)
      IDLE: begin
        if (any) begin
          state_d = GRANT;
          gnt_d   = pick;
          g_d     = pick_idx;
          cnt_d   = '0;
        end
      end
      GRANT: begin
        if (valid_g) begin
          data_d  = byte_g;
          valid_d = 1'b1;
          len_d   = 16'd1;
          flag_d  = error_g;
          state_d = XFER;
        end else if (cnt == 16'(START_TIMEOUT - 1)) begin
          gnt_d   = '0;
          error_d = 1'b1;
          ptr_d   = ptr_next;
          cnt_d   = '0;
          state_d = GAP;
        end else begin
          cnt_d = cnt + 16'd1;
        end
      end
      XFER: begin
        if (!valid_g) begin
          gnt_d   = '0;
          error_d = flag;
          ptr_d   = ptr_next;
          cnt_d   = '0;
          state_d = GAP;
        end else if (len == 16'(MAX_LEN)) begin
          error_d = 1'b1;
          state_d = DRAIN;
        end else begin
          data_d  = byte_g;
          valid_d = 1'b1;
          len_d   = (len == 16'hFFFF) ? len : len + 16'd1;
          flag_d  = flag | error_g;
        end
      end
      DRAIN: begin
        if (!valid_g) begin
          gnt_d   = '0;
          ptr_d   = ptr_next;
          cnt_d   = '0;
          state_d = GAP;
        end
      end
      GAP: begin
        if (cnt == 16'(IFG_CYCLES - 1)) begin
          cnt_d   = '0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt + 16'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      gnt       <= '0;
      g         <= '0;
      ptr       <= '0;
      cnt       <= '0;
      len       <= '0;
      flag      <= 1'b0;
      data_out  <= '0;
      valid_out <= 1'b0;
      error_out <= 1'b0;
    end else begin
      state     <= state_d;
      gnt       <= gnt_d;
      g         <= g_d;
      ptr       <= ptr_d;
      cnt       <= cnt_d;
      len       <= len_d;
      flag      <= flag_d;
      data_out  <= data_d;
      valid_out <= valid_d;
      error_out <= error_d;
    end
  end

endmodule

// File: tb/tb_qnigma_tx_arb.sv
// Self-checking bench for qnigma_tx_arb: scoreboard of expected output
// bytes/error pulses with due cycles, plus per-scenario grant checks.
module tb_qnigma_tx_arb;
  import qnigma_pkg::*;

  localparam int N   = 4;
  localparam int IFG = 12;
  localparam int TO  = 16;
  localparam int ML  = 8;

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   req, gnt, valid_in, error_in;
  logic [N*8-1:0] data_in;
  logic [7:0]     data_out;
  logic           valid_out, error_out, busy;

  typedef struct {
    logic       is_err;
    logic [7:0] data;
    int         due;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;
  logic prev_valid = 1'b0;
  bit   have_prev  = 1'b0;
  int   last_cyc   = 0;

  qnigma_tx_arb #(
    .NUM_REQ       (N),
    .IFG_CYCLES    (IFG),
    .START_TIMEOUT (TO),
    .MAX_LEN       (ML)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .gnt       (gnt),
    .data_in   (data_in),
    .valid_in  (valid_in),
    .error_in  (error_in),
    .data_out  (data_out),
    .valid_out (valid_out),
    .error_out (error_out),
    .busy      (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [N-1:0] onehot(input int r);
    logic [N-1:0] v;
    v    = '0;
    v[r] = 1'b1;
    return v;
  endfunction

  // Output monitor: pops the scoreboard on every valid/error cycle.
  always @(negedge clk) begin
    n_checks++;
    if (!$onehot0(gnt)) begin
      n_fail++;
      $display("FAIL gnt_onehot cyc=%0d gnt=%b", cyc, gnt);
    end
    if (valid_out || error_out) begin
      n_checks++;
      if (valid_out && error_out) begin
        n_fail++;
        $display("FAIL valid_and_error cyc=%0d both high", cyc);
      end else if (sb.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_output cyc=%0d valid=%b error=%b data=%h", cyc, valid_out, error_out, data_out);
      end else begin
        mon_e = sb.pop_front();
        if (mon_e.is_err !== error_out || (!mon_e.is_err && data_out !== mon_e.data) || cyc != mon_e.due) begin
          n_fail++;
          $display("FAIL output_beat got err=%b data=%h cyc=%0d want err=%b data=%h cyc=%0d",
                   error_out, data_out, cyc, mon_e.is_err, mon_e.data, mon_e.due);
        end
      end
    end
    if (valid_out && !prev_valid && have_prev) begin
      n_checks++;
      if (cyc - last_cyc - 1 < IFG) begin
        n_fail++;
        $display("FAIL ifg_gap got=%0d want>=%0d", cyc - last_cyc - 1, IFG);
      end
    end
    if (valid_out) begin
      last_cyc  = cyc;
      have_prev = 1'b1;
    end
    prev_valid = valid_out;
    if (rst) have_prev = 1'b0;
  end

  task automatic push(input bit is_err, input logic [7:0] d, input int due);
    exp_t e;
    e.is_err = is_err;
    e.data   = d;
    e.due    = due;
    sb.push_back(e);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_gnt(input int r, output int gcyc, output bit ok);
    ok   = 1'b0;
    gcyc = 0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (gnt != '0) begin
        ok   = 1'b1;
        gcyc = cyc;
        break;
      end
    end
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL grant_wait r=%0d gnt=%b never asserted", r, gnt);
    end else if (gnt !== onehot(r)) begin
      n_fail++;
      $display("FAIL grant_select got=%b want=%b", gnt, onehot(r));
      ok = 1'b0;
    end
  endtask

  // Called at the negedge where gnt[r] was first seen; returns the cycle in
  // which valid was dropped.
  task automatic send_frame(input int r, input int n, input logic [7:0] base,
                            input logic [7:0] step, input int err_idx, output int end_cyc);
    logic [7:0] d;
    for (int i = 0; i < n; i++) begin
      if (i > 0) begin
        @(negedge clk);
        n_checks++;
        if (gnt !== onehot(r)) begin
          n_fail++;
          $display("FAIL gnt_held byte=%0d got=%b want=%b", i, gnt, onehot(r));
        end
      end
      d = 8'(int'(base) + int'(step) * i);
      valid_in[r]        = 1'b1;
      data_in[8*r +: 8]  = d;
      error_in[r]        = (i == err_idx);
      if (i < ML) push(1'b0, d, cyc + 1);
      else if (i == ML) push(1'b1, 8'h00, cyc + 1);
    end
    @(negedge clk);
    valid_in[r] = 1'b0;
    error_in[r] = 1'b0;
    req[r]      = 1'b0;
    end_cyc     = cyc;
    if (err_idx >= 0 && n <= ML) push(1'b1, 8'h00, cyc + 1);
    @(negedge clk);
    n_checks++;
    if (gnt !== '0) begin
      n_fail++;
      $display("FAIL gnt_release got=%b want=0", gnt);
    end
  endtask

  task automatic check_drained(input string name);
    n_checks++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL %s_drained pending=%0d want=0", name, sb.size());
      sb.delete();
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    idle(3);
    n_checks += 5;
    if (gnt !== '0)        begin n_fail++; $display("FAIL reset_gnt got=%b want=0", gnt); end
    if (data_out !== 8'h0) begin n_fail++; $display("FAIL reset_data got=%h want=00", data_out); end
    if (valid_out !== 1'b0) begin n_fail++; $display("FAIL reset_valid got=%b want=0", valid_out); end
    if (error_out !== 1'b0) begin n_fail++; $display("FAIL reset_error got=%b want=0", error_out); end
    if (busy !== 1'b0)     begin n_fail++; $display("FAIL reset_busy got=%b want=0", busy); end
    rst = 1'b0;
    idle(2);
  endtask

  task automatic test_fairness;
    int order [5] = '{0, 1, 2, 3, 0};
    int g, e;
    bit ok;
    req = '1;
    for (int k = 0; k < 5; k++) begin
      wait_gnt(order[k], g, ok);
      if (ok) send_frame(order[k], 3, 8'(8'h10 * (k + 1)), 8'h01, -1, e);
      req = (k < 4) ? '1 : '0;
    end
    req = '0;
    idle(IFG + 4);
    check_drained("fairness");
  endtask

  task automatic test_single_frame;
    int g, e, g2;
    bit ok;
    req[2] = 1'b1;
    wait_gnt(2, g, ok);
    if (ok) begin
      send_frame(2, 5, 8'h11, 8'h11, -1, e);
      req[0] = 1'b1;
      wait_gnt(0, g2, ok);
      n_checks++;
      if (g2 - (e + 1) != IFG + 1) begin
        n_fail++;
        $display("FAIL next_grant_delay got=%0d want=%0d", g2 - (e + 1), IFG + 1);
      end
      if (ok) send_frame(0, 1, 8'h5A, 8'h00, -1, e);
    end
    req = '0;
    idle(IFG + 4);
    check_drained("single");
  endtask

  task automatic test_oversize;
    int g, e;
    bit ok;
    req[3] = 1'b1;
    wait_gnt(3, g, ok);
    if (ok) send_frame(3, 10, 8'hA0, 8'h01, -1, e);
    req = '0;
    idle(IFG + 4);
    check_drained("oversize");
  endtask

  task automatic test_error_flag;
    int g, e;
    bit ok;
    req[0] = 1'b1;
    wait_gnt(0, g, ok);
    if (ok) send_frame(0, 6, 8'h60, 8'h01, 2, e);
    req = '0;
    idle(IFG + 4);
    check_drained("error_flag");
  endtask

  task automatic test_start_timeout;
    int g, g2, e;
    bit ok;
    req[1] = 1'b1;
    wait_gnt(1, g, ok);
    req[1] = 1'b0;
    if (ok) begin
      push(1'b1, 8'h00, g + TO);
      for (int k = 1; k < TO; k++) begin
        @(negedge clk);
        n_checks++;
        if (gnt !== 4'b0010 || busy !== 1'b1) begin
          n_fail++;
          $display("FAIL timeout_hold k=%0d gnt=%b busy=%b want gnt=0010 busy=1", k, gnt, busy);
        end
      end
      @(negedge clk);
      n_checks++;
      if (gnt !== '0 || busy !== 1'b1) begin
        n_fail++;
        $display("FAIL timeout_drop gnt=%b busy=%b want gnt=0 busy=1", gnt, busy);
      end
      req = '1;
      wait_gnt(2, g2, ok);
      if (ok) send_frame(2, 1, 8'h77, 8'h00, -1, e);
    end
    req = '0;
    idle(IFG + 4);
    check_drained("timeout");
  endtask

  task automatic test_reset_mid_frame;
    int g, e;
    bit ok;
    logic [7:0] d;
    req[1] = 1'b1;
    wait_gnt(1, g, ok);
    if (ok) begin
      for (int i = 0; i < 4; i++) begin
        if (i > 0) @(negedge clk);
        d = 8'(8'hC0 + i);
        valid_in[1]     = 1'b1;
        data_in[15:8]   = d;
        if (i < 3) push(1'b0, d, cyc + 1);
        else rst = 1'b1;
      end
      @(negedge clk);
      n_checks += 4;
      if (valid_out !== 1'b0) begin n_fail++; $display("FAIL rst_mid_valid got=%b want=0", valid_out); end
      if (error_out !== 1'b0) begin n_fail++; $display("FAIL rst_mid_error got=%b want=0", error_out); end
      if (gnt !== '0)         begin n_fail++; $display("FAIL rst_mid_gnt got=%b want=0", gnt); end
      if (busy !== 1'b0)      begin n_fail++; $display("FAIL rst_mid_busy got=%b want=0", busy); end
      valid_in = '0;
      req      = '0;
      @(negedge clk);
      rst = 1'b0;
      req = 4'b1000;
      wait_gnt(3, g, ok);
      if (ok) send_frame(3, 2, 8'hE0, 8'h01, -1, e);
    end
    rst = 1'b0;
    req = '0;
    idle(IFG + 4);
    check_drained("rst_mid");
  endtask

  initial begin
    rst      = 1'b1;
    req      = '0;
    valid_in = '0;
    error_in = '0;
    data_in  = '0;
    test_reset();
    test_fairness();
    test_single_frame();
    test_oversize();
    test_error_flag();
    test_start_timeout();
    test_reset_mid_frame();
    check_drained("final");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
